iter_scheduler: RTL and testbench

ITER_SCHEDULER -- requirements
Module: iter_scheduler

---
 rtl/iter_scheduler.sv | 142 ++++++++++++++
 tb/tb_iter_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_scheduler.sv
// Row/column iteration scheduler: loads each row, then launches one PE per column onto the lowest ready PE.
// Optional ITER_SCHED_PERF_EN adds a saturating stall_cycles counter output.
module iter_scheduler #(
   parameter int unsigned N_MAX  = 4,
   parameter int unsigned M_MAX  = 4,
   parameter int unsigned NUM_PE = 2,
   localparam int unsigned NW = $clog2(N_MAX + 1),
   localparam int unsigned MW = $clog2(M_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [NW-1:0]     n_cfg,
   input  logic [MW-1:0]     m_cfg,
   input  logic              mem_stall,
   input  logic              fifo_full,
   input  logic [NUM_PE-1:0] PE_ready,
   input  logic              abort,
   output logic              load_row,
   output logic [NUM_PE-1:0] start_PE,
   output logic [NW-1:0]     row_idx,
   output logic [MW-1:0]     col_idx,
   output logic              busy,
   output logic              done
`ifdef ITER_SCHED_PERF_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_DISPATCH = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_FIN      = 3'd4
   } state_t;

   state_t          state, state_d;
   logic [NW-1:0]   n_q, n_d, row_d;
   logic [MW-1:0]   m_q, m_d, col_d;
   logic            launch_ok;
   logic            job_start;
   logic            cfg_bad;

   assign launch_ok = !mem_stall && !fifo_full && (|PE_ready);
   assign job_start = (state == ST_IDLE) && start && !abort;
   assign cfg_bad   = (n_cfg == '0) || (m_cfg == '0) ||
                      (n_cfg > NW'(N_MAX)) || (m_cfg > MW'(M_MAX));
   assign busy      = (state != ST_IDLE);
   // An abort during FIN still swallows the completion pulse.
   assign done      = (state == ST_FIN) && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         n_q     <= '0;
         m_q     <= '0;
         row_idx <= '0;
         col_idx <= '0;
      end else begin
         state   <= state_d;
         n_q     <= n_d;
         m_q     <= m_d;
         row_idx <= row_d;
         col_idx <= col_d;
      end
   end

   // Next-state and launch decode; load_row/start_PE are combinational by design.
   always_comb begin
      state_d  = state;
      n_d      = n_q;
      m_d      = m_q;
      row_d    = row_idx;
      col_d    = col_idx;
      load_row = 1'b0;
      start_PE = '0;
      if (abort && (state != ST_IDLE)) begin
         state_d = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (job_start) begin
                  n_d     = n_cfg;
                  m_d     = m_cfg;
                  row_d   = '0;
                  col_d   = '0;
                  state_d = cfg_bad ? ST_FIN : ST_LOAD;
               end
            end
            ST_LOAD: begin
               load_row = !mem_stall;
               if (!mem_stall) state_d = ST_DISPATCH;
            end
            ST_DISPATCH: begin
               if (launch_ok) begin
                  // Isolate the lowest set bit of PE_ready.
                  start_PE = PE_ready & (~PE_ready + NUM_PE'(1));
                  if (col_idx != (m_q - MW'(1))) begin
                     col_d = col_idx + MW'(1);
                  end else if (row_idx != (n_q - NW'(1))) begin
                     row_d   = row_idx + NW'(1);
                     col_d   = '0;
                     state_d = ST_LOAD;
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (&PE_ready) state_d = ST_FIN;
            end
            ST_FIN: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

`ifdef ITER_SCHED_PERF_EN
   logic blocked_c;

   assign blocked_c = ((state == ST_LOAD) && mem_stall) ||
                      ((state == ST_DISPATCH) && (mem_stall || fifo_full));

   // Saturating count of cycles lost to memory or FIFO back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (job_start) begin
         stall_cycles <= '0;
      end else if (blocked_c && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_iter_scheduler.sv
// Directed bench for iter_scheduler: expected load rows and launch positions are queued at job
// start and consumed as the DUT produces load_row / start_PE.
module tb_iter_scheduler;

   localparam int unsigned N_MAX  = 4;
   localparam int unsigned M_MAX  = 4;
   localparam int unsigned NUM_PE = 2;
   localparam int unsigned NW     = $clog2(N_MAX + 1);
   localparam int unsigned MW     = $clog2(M_MAX + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [NW-1:0]     n_cfg;
   logic [MW-1:0]     m_cfg;
   logic              mem_stall;
   logic              fifo_full;
   logic [NUM_PE-1:0] PE_ready;
   logic              abort;
   logic              load_row;
   logic [NUM_PE-1:0] start_PE;
   logic [NW-1:0]     row_idx;
   logic [MW-1:0]     col_idx;
   logic              busy;
   logic              done;

   iter_scheduler #(.N_MAX(N_MAX), .M_MAX(M_MAX), .NUM_PE(NUM_PE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .n_cfg     (n_cfg),
      .m_cfg     (m_cfg),
      .mem_stall (mem_stall),
      .fifo_full (fifo_full),
      .PE_ready  (PE_ready),
      .abort     (abort),
      .load_row  (load_row),
      .start_PE  (start_PE),
      .row_idx   (row_idx),
      .col_idx   (col_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] row_q[$];
   logic [31:0] launch_q[$];
   int  launches, loads, dones;
   logic got_done;
   logic              s_load, s_busy, s_done;
   logic [NUM_PE-1:0] s_pe;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [NUM_PE-1:0] lowest_ready(input logic [NUM_PE-1:0] r);
      logic [NUM_PE-1:0] res;
      logic found;
      res = '0;
      found = 1'b0;
      for (int i = 0; i < int'(NUM_PE); i++) begin
         if (r[i] && !found) begin
            res[i] = 1'b1;
            found  = 1'b1;
         end
      end
      return res;
   endfunction

   // Sample on the falling edge, consume the scoreboard, then return to posedge+1.
   task automatic step();
      logic [31:0] e;
      @(negedge clk);
      s_load = load_row;
      s_pe   = start_PE;
      s_busy = busy;
      s_done = done;
      chk("excl_load_launch", 32'(load_row && (|start_PE)), 32'd0);
      if (!busy) chk("idle_quiet", 32'({load_row, start_PE}), 32'd0);
      if (load_row) begin
         loads++;
         if (row_q.size() == 0) chk("load_unexpected", 32'd1, 32'd0);
         else begin
            e = row_q.pop_front();
            chk("load_row_idx", 32'(row_idx), e);
         end
      end
      if (start_PE != '0) begin
         launches++;
         chk("launch_pe", 32'(start_PE), 32'(lowest_ready(PE_ready)));
         if (launch_q.size() == 0) chk("launch_unexpected", 32'd1, 32'd0);
         else begin
            e = launch_q.pop_front();
            chk("launch_pos", {16'(row_idx), 16'(col_idx)}, e);
         end
      end
      if (done) begin
         dones++;
         got_done = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int n, input int m);
      launches = 0;
      loads    = 0;
      dones    = 0;
      got_done = 1'b0;
      n_cfg    = NW'(n);
      m_cfg    = MW'(m);
      if (n >= 1 && n <= int'(N_MAX) && m >= 1 && m <= int'(M_MAX)) begin
         for (int r = 0; r < n; r++) begin
            row_q.push_back(32'(r));
            for (int c = 0; c < m; c++) launch_q.push_back({16'(r), 16'(c)});
         end
      end
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (!got_done && cyc < budget) begin
         step();
         cyc++;
      end
      chk("done_seen", 32'(got_done), 32'd1);
   endtask

   task automatic finish_job(input int exp_launch, input int exp_load);
      chk("rows_left", 32'(row_q.size()), 32'd0);
      chk("launches_left", 32'(launch_q.size()), 32'd0);
      chk("launch_count", 32'(launches), 32'(exp_launch));
      chk("load_count", 32'(loads), 32'(exp_load));
      step();
      chk("idle_after_fin", 32'(s_busy), 32'd0);
      chk("done_once", 32'(dones), 32'd1);
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0; start = 1'b0; n_cfg = '0; m_cfg = '0;
      mem_stall = 1'b0; fifo_full = 1'b0; PE_ready = '1; abort = 1'b0;
      #12;
      chk("rst_outputs", 32'({load_row, start_PE, busy, done}), 32'd0);
      chk("rst_idx", 32'({row_idx, col_idx}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step();
      chk("idle_busy", 32'(s_busy), 32'd0);

      // Run-through 2x3, no stalls, all PEs ready.
      start_job(2, 3);
      wait_done(40, cyc);
      chk("runthru_done_cycle", 32'(cyc), 32'd10);
      finish_job(6, 2);

      // Memory stall for 8 cycles after start.
      mem_stall = 1'b1;
      start_job(1, 2);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("stall_no_load", 32'(s_load), 32'd0);
         chk("stall_no_launch", 32'(s_pe), 32'd0);
      end
      mem_stall = 1'b0;
      step();
      chk("stall_release_load", 32'(s_load), 32'd1);
      wait_done(20, cyc);
      finish_job(2, 1);

      // FIFO full while dispatching.
      fifo_full = 1'b1;
      start_job(1, 3);
      step();
      chk("fifo_load_ok", 32'(s_load), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("fifo_no_launch", 32'(s_pe), 32'd0);
         chk("fifo_col_held", 32'(col_idx), 32'd0);
      end
      fifo_full = 1'b0;
      step();
      chk("fifo_release_launch", 32'(s_pe), 32'd1);
      wait_done(20, cyc);
      finish_job(3, 1);

      // PE selection and drain.
      PE_ready = 2'b10;
      start_job(1, 2);
      step();
      chk("pe_load", 32'(s_load), 32'd1);
      step();
      chk("pe_sel_hi", 32'(s_pe), 32'b10);
      PE_ready = 2'b00;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pe_none_no_launch", 32'(s_pe), 32'd0);
      end
      chk("pe_none_col", 32'(col_idx), 32'd1);
      PE_ready = 2'b01;
      step();
      chk("pe_sel_lo", 32'(s_pe), 32'b01);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("drain_hold_busy", 32'(s_busy), 32'd1);
         chk("drain_hold_done", 32'(s_done), 32'd0);
      end
      PE_ready = 2'b11;
      step();
      chk("drain_exit_no_done", 32'(s_done), 32'd0);
      step();
      chk("drain_fin_done", 32'(s_done), 32'd1);
      finish_job(2, 1);

      // Abort at row 1 col 1.
      start_job(2, 3);
      for (int i = 0; i < 6; i++) step();
      chk("abort_pos", {16'(row_idx), 16'(col_idx)}, {16'd1, 16'd1});
      abort = 1'b1;
      step();
      chk("abort_suppress", 32'({s_load, s_pe}), 32'd0);
      abort = 1'b0;
      row_q.delete();
      launch_q.delete();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("abort_idle", 32'(s_busy), 32'd0);
      end
      chk("abort_no_done", 32'(dones), 32'd0);

      // Abort and start together in IDLE.
      abort = 1'b1;
      n_cfg = NW'(1); m_cfg = MW'(1); start = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      step();
      chk("abort_start_idle", 32'(s_busy), 32'd0);

      // Zero and out-of-range configurations finish without launches.
      start_job(0, 2);
      wait_done(5, cyc);
      chk("zero_done_cycle", 32'(cyc), 32'd1);
      finish_job(0, 0);
      start_job(5, 1);
      wait_done(5, cyc);
      chk("over_done_cycle", 32'(cyc), 32'd1);
      finish_job(0, 0);

      // Start held high during FIN is ignored.
      start_job(2, 0);
      start = 1'b1;
      step();
      chk("fin_done", 32'(s_done), 32'd1);
      start = 1'b0;
      step();
      chk("fin_start_ignored", 32'(s_busy), 32'd0);

      // Reset mid-job, then a fresh job.
      start_job(2, 2);
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", 32'({load_row, start_PE, busy, done}), 32'd0);
      chk("midrst_idx", 32'({row_idx, col_idx}), 32'd0);
      row_q.delete();
      launch_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      start_job(1, 1);
      wait_done(20, cyc);
      finish_job(1, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
